alu_issue: RTL and testbench
============================

# alu_issue

Decode-and-issue stage that feeds the integer ALU in the RV32I core. It accepts 32-bit instructions over a valid/ready handshake, decodes OP, OP-IMM, LUI and AUIPC into an `alu_op_t` opcode plus two `DPW`-bit operands, and resolves register operands from the register file with write-back forwarding. Results are held in a one-entry pipeline register that presents `opr_a`/`opr_b`/`opcode` to the execute stage under its own valid/ready handshake. Other opcodes are flagged illegal.

## Interface
- `DPW`, 32: datapath width, taken from `rv32i_pkg`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: synchronous kill of the held entry.
- `in_valid` in 1: instruction present.
- `in_ready` out 1: stage accepts the instruction this cycle.
- `instr` in 32: instruction word.
- `pc` in DPW: instruction address.
- `rs1_addr`, `rs2_addr` out 5 each: register-file read addresses, combinational from `instr[19:15]` and `instr[24:20]`.
- `rs1_data`, `rs2_data` in DPW each: register-file read data, same cycle.
- `fwd_valid` in 1, `fwd_addr` in 5, `fwd_data` in DPW: write-back bypass.
- `ex_valid` out 1: held entry valid.
- `ex_ready` in 1: execute consumes the entry.
- `opr_a`, `opr_b` out DPW: ALU operands.
- `opcode` out `alu_op_t`: ALU operation.
- `rd_addr` out 5, `rd_we` out 1: destination register and write enable.
- `illegal` out 1: the held entry is an unsupported or malformed instruction.

## Operation
- Acceptance: `in_ready = !flush && (!ex_valid || ex_ready)`. The entry is loaded when `in_valid && in_ready`.
- Source value: `rsN = 0` when `rsN_addr == 0`. Otherwise it is `fwd_data` when `fwd_valid && fwd_addr == rsN_addr`, else `rsN_data`.
- OP (0110011):
  - `opr_a = rs1`, `opr_b = rs2`.
  - funct3 0 gives ADD_OP with funct7 0000000 and SUB_OP with funct7 0100000.
  - funct3 1/2/3/4/6/7 give SLL/SLT/SLTU/XOR/OR/AND_OP. Each requires funct7 0000000.
  - funct3 5 gives SRL_OP with funct7 0000000 and SRA_OP with funct7 0100000.
- OP-IMM (0010011):
  - `opr_a = rs1`, `opr_b = sign-extended instr[31:20]`, same funct3 mapping with ADD only.
  - SLLI requires instr[31:25]=0. SRLI requires instr[31:25]=0. SRAI requires 0100000.
  - For shifts, `opr_b` is the zero-extended shamt `instr[24:20]`.
- LUI (0110111): ADD_OP, `opr_a = 0`, `opr_b = {instr[31:12], 12'b0}`.
- AUIPC (0010111): ADD_OP, `opr_a = pc`, `opr_b = {instr[31:12], 12'b0}`.
- Illegal (any other opcode or bad funct7): `illegal = 1`, `rd_we = 0`, ADD_OP, operands 0.
- `rd_addr = instr[11:7]`. `rd_we = !illegal && rd_addr != 0`.

## Timing
- Latency is 1 cycle from accept to `ex_valid`. Full throughput is 1 instruction per cycle while `ex_ready = 1`.
- Register update: on accept, all outputs load. Otherwise, if `ex_valid && ex_ready`, `ex_valid` clears. Otherwise all outputs hold stable. Outputs never change while `ex_valid && !ex_ready`.
- Back-to-back: when `ex_ready` and `in_valid` are both 1 with the register full, the old entry leaves and the new one loads in the same cycle.
- `flush`: the next `ex_valid = 0` and no input is accepted that cycle. Flush takes priority over accept and `ex_ready`.
- `rst`: `ex_valid`, `illegal`, `rd_we` = 0. `opr_a`, `opr_b`, `rd_addr` = 0. `opcode` = ADD_OP.
- `rst` dominates `flush`. Reset mid-stall discards the held entry.
- Forwarding is sampled only in the accept cycle. Forward hits on x0 are ignored.

## Structure
- `rv32i_pkg` holds `DPW`, `alu_op_t` (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND_OP), and the major-opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC.
- One sub-module, `alu_decoder`: purely combinational, taking `instr` and producing opcode, operand-select, immediate, `rd_we` and `illegal`.
- `alu_issue` holds the source muxing, forwarding and the pipeline register.

## Test plan
- Reset, then `in_valid=1`, `instr=0x00208133` (add x2,x1,x2) with x1=5, x2=7 → one cycle later `ex_valid=1`, ADD_OP, `opr_a=5`, `opr_b=7`, `rd_addr=2`, `rd_we=1`.
- SRAI `0x4031D093` with x3=0x80000000 → SRA_OP, `opr_b=3`. SLLI with instr[31:25]=0100000 → `illegal=1`, `rd_we=0`.
- LUI `0x123450B7` → `opr_a=0`, `opr_b=0x12345000`. AUIPC with pc=0x100 and imm 0x1 → `opr_a=0x100`, `opr_b=0x1000`.
- Hold `ex_ready=0` for 3 cycles with `in_valid=1` → `in_ready=0` and outputs stable. Release for 4 consecutive instructions → one issued per cycle with none dropped.
- `fwd_valid=1`, `fwd_addr=1`, `fwd_data=0xDEAD` with `rs1_data=0` → `opr_a=0xDEAD`. The same with `rs1_addr=0` → `opr_a=0`.
- `flush` asserted with `in_valid=1` and the register full → next cycle `ex_valid=0` and the input is not accepted. `rst` during a stall → all outputs return to their reset values.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I types: datapath width, ALU opcodes, major opcodes.
// Also holds the operand-select enums used between decode and issue.
package rv32i_pkg;

   localparam int DPW = 32;

   typedef enum logic [3:0] {
      ADD_OP,
      SUB_OP,
      SLL_OP,
      SLT_OP,
      SLTU_OP,
      XOR_OP,
      SRL_OP,
      SRA_OP,
      OR_OP,
      AND_OP
   } alu_op_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      A_RS1,
      A_PC,
      A_ZERO
   } a_sel_t;

   typedef enum logic {
      B_RS2,
      B_IMM
   } b_sel_t;

   // funct3 to operation with funct7 = 0000000
   function automatic alu_op_t base_op(input logic [2:0] f3);
      alu_op_t op;
      case (f3)
         3'd0:    op = ADD_OP;
         3'd1:    op = SLL_OP;
         3'd2:    op = SLT_OP;
         3'd3:    op = SLTU_OP;
         3'd4:    op = XOR_OP;
         3'd5:    op = SRL_OP;
         3'd6:    op = OR_OP;
         default: op = AND_OP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of OP, OP-IMM, LUI and AUIPC for the integer ALU.
// In: instr. Out: opcode, a_sel, b_sel, imm, rd_we, illegal.
module alu_decoder
   import rv32i_pkg::*;
(
   input  logic [31:0]    instr,
   output alu_op_t        opcode,
   output a_sel_t         a_sel,
   output b_sel_t         b_sel,
   output logic [DPW-1:0] imm,
   output logic           rd_we,
   output logic           illegal
);

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;

   assign opc = instr[6:0];
   assign f3  = instr[14:12];
   assign f7  = instr[31:25];

   always_comb begin
      opcode  = ADD_OP;
      a_sel   = A_ZERO;
      b_sel   = B_IMM;
      imm     = '0;
      illegal = 1'b0;
      unique case (1'b1)
         (opc == OPC_OP): begin
            a_sel = A_RS1;
            b_sel = B_RS2;
            if (f7 == F7_BASE)
               opcode = base_op(f3);
            else if (f7 == F7_ALT && f3 == 3'd0)
               opcode = SUB_OP;
            else if (f7 == F7_ALT && f3 == 3'd5)
               opcode = SRA_OP;
            else
               illegal = 1'b1;
         end
         (opc == OPC_OP_IMM): begin
            a_sel  = A_RS1;
            opcode = base_op(f3);
            imm    = {{(DPW-12){instr[31]}}, instr[31:20]};
            // shifts reuse the upper immediate bits as funct7
            if (f3 == 3'd1 || f3 == 3'd5) begin
               imm = {{(DPW-5){1'b0}}, instr[24:20]};
               if (f3 == 3'd5 && f7 == F7_ALT)
                  opcode = SRA_OP;
               else if (f7 != F7_BASE)
                  illegal = 1'b1;
            end
         end
         (opc == OPC_LUI): begin
            imm = DPW'({instr[31:12], 12'b0});
         end
         (opc == OPC_AUIPC): begin
            a_sel = A_PC;
            imm   = DPW'({instr[31:12], 12'b0});
         end
         default: illegal = 1'b1;
      endcase
      // illegal entries carry ADD with zero operands
      if (illegal) begin
         opcode = ADD_OP;
         a_sel  = A_ZERO;
         b_sel  = B_IMM;
         imm    = '0;
      end
      rd_we = !illegal && (instr[11:7] != 5'd0);
   end

endmodule

// File: rtl/alu_issue.sv
// ALU decode-and-issue stage: source mux, write-back bypass, 1-entry reg.
// In: instr/pc/rs data/fwd, handshakes. Out: opr_a/b, opcode, rd, illegal.
module alu_issue
   import rv32i_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [31:0]    instr,
   input  logic [DPW-1:0] pc,
   output logic [4:0]     rs1_addr,
   output logic [4:0]     rs2_addr,
   input  logic [DPW-1:0] rs1_data,
   input  logic [DPW-1:0] rs2_data,
   input  logic           fwd_valid,
   input  logic [4:0]     fwd_addr,
   input  logic [DPW-1:0] fwd_data,
   output logic           ex_valid,
   input  logic           ex_ready,
   output logic [DPW-1:0] opr_a,
   output logic [DPW-1:0] opr_b,
   output alu_op_t        opcode,
   output logic [4:0]     rd_addr,
   output logic           rd_we,
   output logic           illegal
);

   alu_op_t        dec_op;
   a_sel_t         a_sel;
   b_sel_t         b_sel;
   logic [DPW-1:0] dec_imm;
   logic           dec_we;
   logic           dec_ill;
   logic [DPW-1:0] rs1_val;
   logic [DPW-1:0] rs2_val;
   logic [DPW-1:0] a_val;
   logic [DPW-1:0] b_val;
   logic           accept;

   alu_decoder u_dec (
      .instr   (instr),
      .opcode  (dec_op),
      .a_sel   (a_sel),
      .b_sel   (b_sel),
      .imm     (dec_imm),
      .rd_we   (dec_we),
      .illegal (dec_ill)
   );

   assign rs1_addr = instr[19:15];
   assign rs2_addr = instr[24:20];
   assign in_ready = !flush && (!ex_valid || ex_ready);
   assign accept   = in_valid && in_ready;

   // x0 reads as zero and never takes a bypass hit
   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (rs1_addr != 5'd0)
         rs1_val = (fwd_valid && fwd_addr == rs1_addr) ? fwd_data : rs1_data;
      if (rs2_addr != 5'd0)
         rs2_val = (fwd_valid && fwd_addr == rs2_addr) ? fwd_data : rs2_data;
   end

   always_comb begin
      unique case (a_sel)
         A_RS1:   a_val = rs1_val;
         A_PC:    a_val = pc;
         default: a_val = '0;
      endcase
      b_val = (b_sel == B_RS2) ? rs2_val : dec_imm;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid <= 1'b0;
         opr_a    <= '0;
         opr_b    <= '0;
         opcode   <= ADD_OP;
         rd_addr  <= 5'd0;
         rd_we    <= 1'b0;
         illegal  <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (accept) begin
         ex_valid <= 1'b1;
         opr_a    <= a_val;
         opr_b    <= b_val;
         opcode   <= dec_op;
         rd_addr  <= instr[11:7];
         rd_we    <= dec_we;
         illegal  <= dec_ill;
      end else if (ex_valid && ex_ready) begin
         ex_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus random traffic.
// Expected state comes from a spec-level decode model and entry tracker.
module tb_alu_issue;
   import rv32i_pkg::*;

   logic           clk = 1'b0;
   logic           rst, flush, in_valid, in_ready;
   logic [31:0]    instr;
   logic [DPW-1:0] pc;
   logic [4:0]     rs1_addr, rs2_addr;
   logic [DPW-1:0] rs1_data, rs2_data;
   logic           fwd_valid;
   logic [4:0]     fwd_addr;
   logic [DPW-1:0] fwd_data;
   logic           ex_valid, ex_ready;
   logic [DPW-1:0] opr_a, opr_b;
   alu_op_t        opcode;
   logic [4:0]     rd_addr;
   logic           rd_we, illegal;

   logic [DPW-1:0] regs [32];

   typedef struct packed {
      logic        v;
      logic [31:0] a;
      logic [31:0] b;
      alu_op_t     op;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
   } exp_t;

   exp_t held;
   exp_t snap;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   assign rs1_data = regs[rs1_addr];
   assign rs2_data = regs[rs2_addr];

   alu_issue dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .pc        (pc),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .fwd_valid (fwd_valid),
      .fwd_addr  (fwd_addr),
      .fwd_data  (fwd_data),
      .ex_valid  (ex_valid),
      .ex_ready  (ex_ready),
      .opr_a     (opr_a),
      .opr_b     (opr_b),
      .opcode    (opcode),
      .rd_addr   (rd_addr),
      .rd_we     (rd_we),
      .illegal   (illegal)
   );

   function automatic exp_t reset_val();
      exp_t e;
      e = '{v: 1'b0, a: '0, b: '0, op: ADD_OP, rd: '0, we: 1'b0, ill: 1'b0};
      return e;
   endfunction

   function automatic exp_t dut_now();
      exp_t e;
      e = '{v: ex_valid, a: opr_a, b: opr_b, op: opcode,
            rd: rd_addr, we: rd_we, ill: illegal};
      return e;
   endfunction

   function automatic string fmt(input exp_t e);
      return $sformatf("v=%0b a=%h b=%h op=%s rd=%0d we=%0b ill=%0b",
                       e.v, e.a, e.b, e.op.name(), e.rd, e.we, e.ill);
   endfunction

   // register value as the instruction sees it
   function automatic logic [31:0] src(input logic [4:0] r);
      if (r == 0) return 32'd0;
      if (fwd_valid && fwd_addr == r) return fwd_data;
      return regs[r];
   endfunction

   function automatic alu_op_t op_of(input logic [2:0] f3);
      alu_op_t t [8];
      t = '{ADD_OP, SLL_OP, SLT_OP, SLTU_OP, XOR_OP, SRL_OP, OR_OP, AND_OP};
      return t[f3];
   endfunction

   function automatic exp_t model(input logic [31:0] i, input logic [31:0] p);
      exp_t        e;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [31:0] upper;
      f7    = i[31:25];
      f3    = i[14:12];
      upper = {i[31:12], 12'h000};
      e     = '{v: 1'b1, a: '0, b: '0, op: ADD_OP, rd: i[11:7],
                we: 1'b0, ill: 1'b0};
      if (i[6:0] == 7'h33) begin
         e.a = src(i[19:15]);
         e.b = src(i[24:20]);
         if (f7 == 7'h00) e.op = op_of(f3);
         else if (f7 == 7'h20 && f3 == 0) e.op = SUB_OP;
         else if (f7 == 7'h20 && f3 == 5) e.op = SRA_OP;
         else e.ill = 1'b1;
      end else if (i[6:0] == 7'h13) begin
         e.a  = src(i[19:15]);
         e.op = op_of(f3);
         if (f3 == 1 || f3 == 5) begin
            e.b = 32'(i[24:20]);
            if (f3 == 5 && f7 == 7'h20) e.op = SRA_OP;
            else if (f7 != 0) e.ill = 1'b1;
         end else begin
            e.b = 32'($signed(i[31:20]));
         end
      end else if (i[6:0] == 7'h37) begin
         e.b = upper;
      end else if (i[6:0] == 7'h17) begin
         e.a = p;
         e.b = upper;
      end else begin
         e.ill = 1'b1;
      end
      if (e.ill) begin
         e.a  = '0;
         e.b  = '0;
         e.op = ADD_OP;
      end
      e.we = !e.ill && e.rd != 0;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0] opc, f7;
      int s;
      s = $urandom_range(0, 9);
      if (s < 4) opc = 7'h33;
      else if (s < 7) opc = 7'h13;
      else if (s == 7) opc = 7'h37;
      else if (s == 8) opc = 7'h17;
      else opc = 7'($urandom);
      s = $urandom_range(0, 5);
      f7 = (s < 3) ? 7'h00 : (s < 5) ? 7'h20 : 7'($urandom);
      return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              3'($urandom), 5'($urandom), opc};
   endfunction

   // one clock: check in_ready, advance the model, check the entry
   task automatic cycle(input string name);
      exp_t nxt;
      logic rdy;
      #1;
      rdy = !flush && (!held.v || ex_ready);
      n_tests++;
      if (in_ready !== rdy) begin
         n_fail++;
         $display("FAIL %s in_ready got %b want %b", name, in_ready, rdy);
      end
      nxt = held;
      if (rst) nxt = reset_val();
      else if (flush) nxt.v = 1'b0;
      else if (in_valid && rdy) nxt = model(instr, pc);
      else if (held.v && ex_ready) nxt.v = 1'b0;
      @(posedge clk);
      #1;
      held = nxt;
      n_tests++;
      if (dut_now() !== held) begin
         n_fail++;
         $display("FAIL %s entry got {%s} want {%s}", name,
                  fmt(dut_now()), fmt(held));
      end
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      flush     = 1'b0;
      fwd_valid = 1'b0;
      ex_ready  = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      instr = 32'h0;
      pc = '0;
      fwd_addr = '0;
      fwd_data = '0;
      for (int i = 0; i < 32; i++) regs[i] = 32'($urandom);
      @(posedge clk);
      #1;
      held = reset_val();
      rst = 1'b0;
      n_tests++;
      if (dut_now() !== reset_val()) begin
         n_fail++;
         $display("FAIL reset got {%s}", fmt(dut_now()));
      end
   endtask

   task automatic test_add();
      regs[1] = 5;
      regs[2] = 7;
      in_valid = 1'b1;
      instr = 32'h00208133;
      cycle("add");
      in_valid = 1'b0;
      n_tests++;
      if (!(ex_valid === 1 && opcode === ADD_OP && opr_a === 5 &&
            opr_b === 7 && rd_addr === 2 && rd_we === 1)) begin
         n_fail++;
         $display("FAIL add_fixed got {%s}", fmt(dut_now()));
      end
      cycle("add_drain");
   endtask

   task automatic test_shift_imm();
      regs[3] = 32'h80000000;
      in_valid = 1'b1;
      instr = 32'h4031D093;
      cycle("srai");
      n_tests++;
      if (opcode !== SRA_OP || opr_b !== 3 || opr_a !== 32'h80000000) begin
         n_fail++;
         $display("FAIL srai got {%s}", fmt(dut_now()));
      end
      instr = {7'h20, 5'd2, 5'd1, 3'd1, 5'd4, 7'h13};
      cycle("slli_bad");
      n_tests++;
      if (illegal !== 1 || rd_we !== 0 || ex_valid !== 1) begin
         n_fail++;
         $display("FAIL slli_bad got {%s}", fmt(dut_now()));
      end
      in_valid = 1'b0;
      cycle("shift_drain");
   endtask

   task automatic test_upper();
      in_valid = 1'b1;
      instr = 32'h123450B7;
      cycle("lui");
      n_tests++;
      if (opr_a !== 0 || opr_b !== 32'h12345000 || opcode !== ADD_OP) begin
         n_fail++;
         $display("FAIL lui got {%s}", fmt(dut_now()));
      end
      pc = 32'h100;
      instr = {20'h00001, 5'd3, 7'h17};
      cycle("auipc");
      n_tests++;
      if (opr_a !== 32'h100 || opr_b !== 32'h1000 || rd_we !== 1) begin
         n_fail++;
         $display("FAIL auipc got {%s}", fmt(dut_now()));
      end
      in_valid = 1'b0;
      cycle("upper_drain");
   endtask

   task automatic test_stall();
      in_valid = 1'b1;
      ex_ready = 1'b0;
      instr = 32'h00208133;
      cycle("stall_fill");
      snap = held;
      for (int k = 0; k < 3; k++) begin
         instr = {7'h00, 5'd2, 5'd1, 3'd4, 5'(k + 7), 7'h33};
         cycle("stall_hold");
         n_tests++;
         if (in_ready !== 0 || dut_now() !== snap) begin
            n_fail++;
            $display("FAIL stall_stable rdy=%b got {%s}", in_ready,
                     fmt(dut_now()));
         end
      end
      ex_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         instr = {7'h00, 5'd2, 5'd1, 3'd6, 5'(k), 7'h33};
         cycle("b2b");
         n_tests++;
         if (ex_valid !== 1 || rd_addr !== 5'(k) || opcode !== OR_OP) begin
            n_fail++;
            $display("FAIL b2b_%0d got {%s}", k, fmt(dut_now()));
         end
      end
      in_valid = 1'b0;
      cycle("b2b_drain");
   endtask

   task automatic test_forward();
      regs[1] = 0;
      fwd_valid = 1'b1;
      fwd_addr = 5'd1;
      fwd_data = 32'hDEAD;
      in_valid = 1'b1;
      instr = {7'h00, 5'd0, 5'd1, 3'd0, 5'd5, 7'h33};
      cycle("fwd_hit");
      n_tests++;
      if (opr_a !== 32'hDEAD) begin
         n_fail++;
         $display("FAIL fwd_hit opr_a got %h want 0000dead", opr_a);
      end
      fwd_addr = 5'd0;
      instr = {7'h00, 5'd2, 5'd0, 3'd0, 5'd5, 7'h33};
      cycle("fwd_x0");
      n_tests++;
      if (opr_a !== 0) begin
         n_fail++;
         $display("FAIL fwd_x0 opr_a got %h want 00000000", opr_a);
      end
      idle();
      cycle("fwd_drain");
   endtask

   task automatic test_flush();
      in_valid = 1'b1;
      ex_ready = 1'b0;
      instr = 32'h123450B7;
      cycle("flush_fill");
      flush = 1'b1;
      instr = 32'h00208133;
      cycle("flush");
      n_tests++;
      if (ex_valid !== 0) begin
         n_fail++;
         $display("FAIL flush ex_valid got %b want 0", ex_valid);
      end
      flush = 1'b0;
      in_valid = 1'b0;
      cycle("flush_after");
      n_tests++;
      if (ex_valid !== 0) begin
         n_fail++;
         $display("FAIL flush_noaccept ex_valid got %b want 0", ex_valid);
      end
   endtask

   task automatic test_reset_stall();
      in_valid = 1'b1;
      ex_ready = 1'b0;
      instr = 32'h4031D093;
      cycle("rst_fill");
      cycle("rst_hold");
      rst = 1'b1;
      flush = 1'b1;
      cycle("rst_stall");
      rst = 1'b0;
      idle();
      n_tests++;
      if (dut_now() !== reset_val()) begin
         n_fail++;
         $display("FAIL rst_stall got {%s}", fmt(dut_now()));
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 15) == 0)
            for (int i = 0; i < 32; i++) regs[i] = 32'($urandom);
         in_valid  = ($urandom_range(0, 3) != 0);
         ex_ready  = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         rst       = ($urandom_range(0, 49) == 0);
         fwd_valid = $urandom_range(0, 1);
         fwd_addr  = 5'($urandom_range(0, 3));
         fwd_data  = 32'($urandom);
         pc        = 32'($urandom) & ~32'h3;
         instr     = rand_instr();
         cycle("random");
      end
      rst = 1'b0;
      idle();
      cycle("random_drain");
   endtask

   initial begin
      test_reset();
      test_add();
      test_shift_imm();
      test_upper();
      test_stall();
      test_forward();
      test_flush();
      test_reset_stall();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
